sop_sweeper: RTL and testbench
==============================

Name: sop_sweeper

Overview:
- Parametrised, programmable successor to the fixed 4-input sum-of-products unit.
- Holds a loadable minterm mask for an N-input boolean function, evaluated in SoP or PoS interpretation.
- Provides a registered direct-evaluation path and a sequential truth-table sweep that streams (m, f(m)) pairs under valid/ready handshake, then reports a count of true rows.
- Sits between testbench/stimulus logic and display/check logic in the lab datapath.

Parameters:
N, 4, number of function inputs (1..8)
ROWS, 2**N, truth-table rows; derived, not overridden

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
load  input  1  capture mask_in into mask register (IDLE only)
mask_in  input  ROWS  bit i set = index i listed (minterm in SoP, maxterm in PoS)
pos_mode  input  1  0 = SoP (f=mask[i]), 1 = PoS (f=~mask[i]); sampled with load
x  input  N  direct-evaluation input vector
s  output  1  registered f(x)
start  input  1  begin sweep (IDLE only)
busy  output  1  high in SWEEP and DONE
m_out  output  N  current sweep row index
f_out  output  1  f(m_out)
out_valid  output  1  m_out/f_out valid
out_ready  input  1  consumer accepts the current row
done  output  1  one-cycle pulse after the last row is accepted
ones_count  output  N+1  number of rows with f=1 in the last completed sweep

Behaviour:
- Reset (asynchronous, any state):
  - mask=0, pos_q=0, state=IDLE.
  - s=0, busy=0, m_out=0, f_out=0, out_valid=0, done=0, ones_count=0.
  - A reset mid-sweep aborts the sweep with no done pulse.
- Mask/mode load:
  - In IDLE with load=1, mask<=mask_in and pos_q<=pos_mode at the clock edge.
  - load is ignored in SWEEP and DONE.
  - If load and start are both high in IDLE, load wins this cycle and start is ignored.
- Direct path:
  - s <= pos_q ? ~mask[x] : mask[x] every cycle, in any state. Latency 1 cycle.
  - Uses the mask/mode in effect before the edge, so a load takes effect for s one cycle later.
- States: IDLE, SWEEP, DONE.
  - IDLE -> SWEEP on start=1 (and load=0):
    - m_out<=0, out_valid<=1, f_out<=f(0), busy<=1, internal count cleared.
  - SWEEP:
    - A row transfers when out_valid & out_ready.
    - On transfer, add f_out to the internal count (N+1 bits, no overflow possible; max ROWS).
    - If m_out < ROWS-1: m_out<=m_out+1 and f_out<=f(m_out+1), with out_valid held at 1. Back-to-back rows are therefore one per cycle.
    - If m_out == ROWS-1: out_valid<=0, ones_count<=count+f_out, next state DONE.
    - When out_ready=0, m_out, f_out and out_valid hold stable. No row may change while presented.
  - DONE: done=1 for exactly one cycle, busy=1, then IDLE (busy<=0).
- start is ignored outside IDLE, and start held high in IDLE re-launches a new sweep.
- ones_count holds its value until the next sweep completes. It is not updated by an aborted (reset) sweep; reset clears it.
- m_out stays at ROWS-1 after a sweep. Its wrap to 0 occurs only at the next start.
- f_out uses the mask/mode latched at start; the mask cannot change mid-sweep because load is blocked.

Decomposition:
- Shared package sop_pkg holds:
  - State enum type (IDLE, SWEEP, DONE).
  - Constant DEFAULT_MASK_4 = 16'h5363, the minterms 0,1,5,6,8,9,C,E.
  - Function rows_of(N).
- One natural sub-module, sop_lut: combinational mask/mode/index -> f. It is instantiated twice, once for the direct path (x) and once for the sweep path (next index).

Test Plan:
1. Reset mid-sweep: assert reset after 5 accepted rows -> all outputs 0 immediately (asynchronous), no done pulse, mask=0, s=0 on next cycle.
2. SoP load, mask_in=16'h5363, pos_mode=0, then direct x=5 -> s=1 one cycle later; x=2 -> s=0; x=4'hE -> s=1; x=4'hF -> s=0.
3. Sweep with out_ready=1, same mask -> 16 consecutive rows m=0..F, f=1,1,0,0,0,1,1,0,1,1,0,0,1,0,1,0; done pulses the cycle after m=F is accepted; ones_count=8; busy low again one cycle later.
4. Backpressure: out_ready toggling 1,0,0,1,... -> m_out/f_out stable while out_ready=0, no row skipped or duplicated, ones_count still 8.
5. PoS mode: load 16'h5363 with pos_mode=1, sweep -> f inverted (m=2 gives f=1, m=0 gives f=0), ones_count=8.
6. Load and start in the same IDLE cycle -> mask captured, no sweep. load during SWEEP -> ignored, sweep results unchanged. start during SWEEP -> ignored.

Source files
------------

// File: rtl/sop_pkg.sv
// rtl/sop_pkg.sv - shared types, constants and helpers for the sum-of-products sweeper
package sop_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } sop_state_t;

    // Minterms 0,1,5,6,8,9,C,E of the original fixed 4-input unit
    localparam logic [15:0] DEFAULT_MASK_4 = 16'h5363;

    function automatic int rows_of(input int n);
        return 1 << n;
    endfunction

endpackage

// File: rtl/sop_lut.sv
// rtl/sop_lut.sv - combinational truth-table lookup of f for one index in SoP or PoS form
module sop_lut
    import sop_pkg::*;
#(
    parameter int N = 4,
    localparam int ROWS = rows_of(N)
) (
    input  logic [ROWS-1:0] mask,
    input  logic            pos,
    input  logic [N-1:0]    idx,
    output logic            f
);

    // A listed index is a minterm in SoP (f=1) and a maxterm in PoS (f=0)
    assign f = mask[idx] ^ pos;

endmodule

// File: rtl/sop_sweeper.sv
// rtl/sop_sweeper.sv - programmable N-input SoP/PoS unit with direct evaluation and a
// handshaked truth-table sweep that reports the number of true rows
module sop_sweeper
    import sop_pkg::*;
#(
    parameter int N = 4,
    localparam int ROWS = rows_of(N)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load,
    input  logic [ROWS-1:0] mask_in,
    input  logic            pos_mode,
    input  logic [N-1:0]    x,
    output logic            s,
    input  logic            start,
    output logic            busy,
    output logic [N-1:0]    m_out,
    output logic            f_out,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            done,
    output logic [N:0]      ones_count
);

    sop_state_t      state;
    sop_state_t      state_next;
    logic [ROWS-1:0] mask;
    logic            pos_q;
    logic [N:0]      count;
    logic [N-1:0]    sweep_idx;
    logic            f_direct;
    logic            f_sweep;
    logic            launch;
    logic            xfer;
    logic            last_row;

    sop_lut #(.N(N)) u_lut_direct (
        .mask (mask),
        .pos  (pos_q),
        .idx  (x),
        .f    (f_direct)
    );

    // The sweep lookup always points at the row to be presented next
    assign sweep_idx = launch ? '0 : m_out + N'(1);

    sop_lut #(.N(N)) u_lut_sweep (
        .mask (mask),
        .pos  (pos_q),
        .idx  (sweep_idx),
        .f    (f_sweep)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        launch     = 1'b0;
        xfer       = out_valid & out_ready;
        last_row   = (m_out == N'(ROWS - 1));
        case (state)
            IDLE: begin
                // load takes priority over start in the same cycle
                if (start && !load) begin
                    launch     = 1'b1;
                    state_next = SWEEP;
                end
            end
            SWEEP: begin
                if (xfer && last_row) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mask       <= '0;
            pos_q      <= 1'b0;
            s          <= 1'b0;
            m_out      <= '0;
            f_out      <= 1'b0;
            out_valid  <= 1'b0;
            count      <= '0;
            ones_count <= '0;
        end else begin
            s <= f_direct;
            if (state == IDLE && load) begin
                mask  <= mask_in;
                pos_q <= pos_mode;
            end
            if (launch) begin
                m_out     <= '0;
                f_out     <= f_sweep;
                out_valid <= 1'b1;
                count     <= '0;
            end else if (xfer) begin
                count <= count + {{N{1'b0}}, f_out};
                if (last_row) begin
                    out_valid  <= 1'b0;
                    ones_count <= count + {{N{1'b0}}, f_out};
                end else begin
                    m_out <= m_out + N'(1);
                    f_out <= f_sweep;
                end
            end
        end
    end

endmodule

// File: tb/tb_sop_sweeper.sv
// tb/tb_sop_sweeper.sv - self-checking bench for sop_sweeper with a spec-level reference model
module tb_sop_sweeper;
    import sop_pkg::*;

    localparam int N    = 4;
    localparam int ROWS = 16;

    logic            clk = 1'b0;
    logic            reset;
    logic            load;
    logic [ROWS-1:0] mask_in;
    logic            pos_mode;
    logic [N-1:0]    x;
    logic            s;
    logic            start;
    logic            busy;
    logic [N-1:0]    m_out;
    logic            f_out;
    logic            out_valid;
    logic            out_ready;
    logic            done;
    logic [N:0]      ones_count;

    int vectors     = 0;
    int miscompares = 0;

    sop_sweeper #(.N(N)) dut (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .mask_in    (mask_in),
        .pos_mode   (pos_mode),
        .x          (x),
        .s          (s),
        .start      (start),
        .busy       (busy),
        .m_out      (m_out),
        .f_out      (f_out),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .done       (done),
        .ones_count (ones_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic f_of(input logic [ROWS-1:0] mk, input logic p, input int i);
        return mk[i] ^ p;
    endfunction

    // Reference model: phase 0 idle, 1 presenting rows, 2 done pulse
    logic [ROWS-1:0] md_mask;
    logic            md_pos;
    logic            md_s;
    int              md_phase;
    int              md_idx;
    int              md_cnt;
    int              md_ones;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            md_mask  <= '0;
            md_pos   <= 1'b0;
            md_s     <= 1'b0;
            md_phase <= 0;
            md_idx   <= 0;
            md_cnt   <= 0;
            md_ones  <= 0;
        end else begin
            md_s <= f_of(md_mask, md_pos, int'(x));
            if (md_phase == 0) begin
                if (load) begin
                    md_mask <= mask_in;
                    md_pos  <= pos_mode;
                end else if (start) begin
                    md_phase <= 1;
                    md_idx   <= 0;
                    md_cnt   <= 0;
                end
            end else if (md_phase == 1) begin
                if (out_ready) begin
                    md_cnt <= md_cnt + int'(f_of(md_mask, md_pos, md_idx));
                    if (md_idx == ROWS - 1) begin
                        md_ones  <= md_cnt + int'(f_of(md_mask, md_pos, md_idx));
                        md_phase <= 2;
                    end else begin
                        md_idx <= md_idx + 1;
                    end
                end
            end else begin
                md_phase <= 0;
            end
        end
    end

    logic [ROWS-1:0] cap;
    int              cap_n;
    int              done_cnt = 0;

    always @(negedge clk) begin
        if (!reset) begin
            check("s", 32'(s), 32'(md_s));
            check("busy", 32'(busy), 32'(md_phase != 0));
            check("done", 32'(done), 32'(md_phase == 2));
            check("out_valid", 32'(out_valid), 32'(md_phase == 1));
            check("m_out", 32'(m_out), 32'(md_idx));
            check("ones_count", 32'(ones_count), 32'(md_ones));
            if (md_phase == 1)
                check("f_out", 32'(f_out), 32'(f_of(md_mask, md_pos, md_idx)));
            if (out_valid && out_ready) begin
                cap[m_out] = f_out;
                cap_n++;
            end
            if (done) done_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [ROWS-1:0] mk, input logic p);
        load = 1'b1; mask_in = mk; pos_mode = p;
        tick();
        load = 1'b0;
    endtask

    task automatic direct(input logic [N-1:0] xv, input logic exp, input string name);
        x = xv;
        tick();
        check(name, 32'(s), 32'(exp));
    endtask

    task automatic sweep(input bit bp, input string name);
        logic [3:0] pat;
        int k;
        pat = 4'b1001;
        cap = '0; cap_n = 0; k = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        while (!done && k < 200) begin
            if (bp) out_ready = pat[k % 4];
            tick();
            k++;
        end
        check({name, "_done_reached"}, 32'(done), 32'd1);
        out_ready = 1'b1;
    endtask

    initial begin
        reset = 1'b1; load = 1'b0; mask_in = '0; pos_mode = 1'b0;
        x = '0; start = 1'b0; out_ready = 1'b1;
        tick(); tick();
        check("rst_ones_count", 32'(ones_count), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        reset = 1'b0;

        // SoP direct evaluation
        do_load(DEFAULT_MASK_4, 1'b0);
        direct(4'h5, 1'b1, "sop_x5");
        direct(4'h2, 1'b0, "sop_x2");
        direct(4'hE, 1'b1, "sop_xE");
        direct(4'hF, 1'b0, "sop_xF");

        // full-rate sweep
        out_ready = 1'b1;
        sweep(1'b0, "sop_sweep");
        check("sop_rows", 32'(cap), 32'h5363);
        check("sop_row_cnt", 32'(cap_n), 32'd16);
        check("sop_ones", 32'(ones_count), 32'd8);
        tick();
        check("sop_busy_after", 32'(busy), 32'd0);

        // backpressure
        sweep(1'b1, "bp_sweep");
        check("bp_rows", 32'(cap), 32'h5363);
        check("bp_row_cnt", 32'(cap_n), 32'd16);
        check("bp_ones", 32'(ones_count), 32'd8);
        tick();

        // PoS
        do_load(DEFAULT_MASK_4, 1'b1);
        sweep(1'b0, "pos_sweep");
        check("pos_rows", 32'(cap), 32'hAC9C);
        check("pos_m2", 32'(cap[2]), 32'd1);
        check("pos_m0", 32'(cap[0]), 32'd0);
        check("pos_ones", 32'(ones_count), 32'd8);
        tick();

        // load and start together: load wins, no sweep
        load = 1'b1; start = 1'b1; mask_in = 16'h000F; pos_mode = 1'b0;
        tick();
        load = 1'b0; start = 1'b0;
        check("ld_st_busy", 32'(busy), 32'd0);
        direct(4'h0, 1'b1, "ld_st_x0");
        direct(4'h8, 1'b0, "ld_st_x8");

        // load and start during a sweep are ignored
        start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();
        load = 1'b1; mask_in = 16'hFFFF; start = 1'b1;
        tick();
        load = 1'b0; start = 1'b0;
        begin
            int k;
            k = 0;
            while (!done && k < 200) begin tick(); k++; end
            check("blk_done_reached", 32'(done), 32'd1);
        end
        check("blk_ones", 32'(ones_count), 32'd4);
        tick();
        check("blk_idle", 32'(busy), 32'd0);
        direct(4'h8, 1'b0, "blk_mask_kept");

        // reset after five accepted rows
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        check("pre_rst_m", 32'(m_out), 32'd5);
        begin
            int dc;
            dc = done_cnt;
            x = 4'h3;
            #2 reset = 1'b1;
            #1;
            check("arst_out", {20'd0, s, busy, m_out, f_out, out_valid, done, ones_count}, 32'd0);
            tick();
            reset = 1'b0;
            tick();
            check("arst_s_mask0", 32'(s), 32'd0);
            repeat (3) tick();
            check("arst_no_done", 32'(done_cnt), 32'(dc));
            check("arst_idle", 32'(busy), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
